// File: rtl/adder_issue_arbiter.sv
`default_nettype none
// ============================================================================
// adder_issue_arbiter : round-robin sharing of one adder among issue requesters
// Rev 1.0
// ============================================================================

package adder_issue_pkg;
  typedef logic [31:0] DATA;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'd0,
    OPA_IS_NPC  = 2'd1,
    OPA_IS_PC   = 2'd2,
    OPA_IS_ZERO = 2'd3
  } ALU_OPA_SELECT;

  typedef enum logic [2:0] {
    OPB_IS_RS2   = 3'd0,
    OPB_IS_I_IMM = 3'd1,
    OPB_IS_S_IMM = 3'd2,
    OPB_IS_B_IMM = 3'd3,
    OPB_IS_U_IMM = 3'd4,
    OPB_IS_J_IMM = 3'd5
  } ALU_OPB_SELECT;

  typedef struct packed {
    DATA           inst;
    DATA           PC;
    DATA           NPC;
    DATA           rs1_value;
    DATA           rs2_value;
    ALU_OPA_SELECT opa_select;
    ALU_OPB_SELECT opb_select;
    logic [4:0]    dest_reg_idx;
    logic [5:0]    rob_idx;
  } ISSUE_PACKET;
endpackage

module basic_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

module adder_issue_arbiter
  import adder_issue_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  ISSUE_PACKET        req_pack [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  output DATA                out_result,
  output logic [IDX_W-1:0]   out_src,
  output ISSUE_PACKET        out_pack,
  input  logic               out_ready
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   c_NUM  = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_s1_valid;
  ISSUE_PACKET      r_s1_pack;
  logic [IDX_W-1:0] r_s1_src;
  logic             r_out_valid;
  DATA              r_out_result;
  logic [IDX_W-1:0] r_out_src;
  ISSUE_PACKET      r_out_pack;

  logic               w_s2_free, w_s1_adv, w_s1_free;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_any, w_found;
  logic [IDX_W:0]     w_cand;
  DATA                w_inst, w_opa, w_opb, w_sum;

  assign w_s2_free = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s2_free;

  // Scan from the pointer upward, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
      if (w_cand >= c_NUM) w_cand = w_cand - c_NUM;
      if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
    if (w_found && w_s1_free && !flush && !reset) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_any = |w_grant;
  assign req_ready = w_grant;

  assign w_inst = r_s1_pack.inst;

  always_comb begin
    w_opa = r_s1_pack.rs1_value;
    case (r_s1_pack.opa_select)
      OPA_IS_RS1:  w_opa = r_s1_pack.rs1_value;
      OPA_IS_NPC:  w_opa = r_s1_pack.NPC;
      OPA_IS_PC:   w_opa = r_s1_pack.PC;
      OPA_IS_ZERO: w_opa = '0;
      default:     w_opa = r_s1_pack.rs1_value;
    endcase
  end

  // Immediates are decoded from the RISC-V instruction word.
  always_comb begin
    w_opb = '0;
    case (r_s1_pack.opb_select)
      OPB_IS_RS2:   w_opb = r_s1_pack.rs2_value;
      OPB_IS_I_IMM: w_opb = {{20{w_inst[31]}}, w_inst[31:20]};
      OPB_IS_S_IMM: w_opb = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      OPB_IS_B_IMM: w_opb = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      OPB_IS_U_IMM: w_opb = {w_inst[31:12], 12'b0};
      OPB_IS_J_IMM: w_opb = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      default:      w_opb = '0;
    endcase
  end

  basic_adder u_adder (
    .i_a   (w_opa),
    .i_b   (w_opb),
    .o_sum (w_sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_pack    <= '0;
      r_s1_src     <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_src    <= '0;
      r_out_pack   <= '0;
    end else begin
      if (w_gnt_any) r_rr_ptr <= (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + IDX_W'(1);

      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_gnt_any) begin
        r_s1_valid <= 1'b1;
        r_s1_pack  <= req_pack[w_gnt_idx];
        r_s1_src   <= w_gnt_idx;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // A consumer pop in the flush cycle simply completes; nothing refills S2.
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_sum;
        r_out_pack   <= r_s1_pack;
        r_out_src    <= r_s1_src;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_src    = r_out_src;
  assign out_pack   = r_out_pack;

endmodule
`default_nettype wire

// File: tb/tb_adder_issue_arbiter.sv
`default_nettype none
// Bench for adder_issue_arbiter: expected sums queued at grant, compared at the result handshake.
module tb_adder_issue_arbiter;
  import adder_issue_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic               clock = 1'b0;
  logic               reset, flush, out_ready, out_valid;
  logic [NUM_REQ-1:0] req_valid, req_ready;
  ISSUE_PACKET        req_pack [NUM_REQ];
  DATA                out_result;
  logic [IDX_W-1:0]   out_src;
  ISSUE_PACKET        out_pack;

  typedef struct {
    logic [IDX_W-1:0] src;
    DATA              result;
    ISSUE_PACKET      pack;
  } exp_t;

  exp_t       sb_q [$];
  DATA        exp_sum [NUM_REQ];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_acc    = 0;
  logic [5:0] rob_ctr  = '0;
  DATA        held_res;
  logic [NUM_REQ-1:0] exp_gnt;

  always #5 clock = ~clock;

  adder_issue_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_pack   (req_pack),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_src    (out_src),
    .out_pack   (out_pack),
    .out_ready  (out_ready)
  );

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic ISSUE_PACKET base_pack(input logic [5:0] tag);
    ISSUE_PACKET p;
    p              = '0;
    p.inst         = $urandom;
    p.PC           = $urandom;
    p.NPC          = $urandom;
    p.rs1_value    = $urandom;
    p.rs2_value    = $urandom;
    p.rob_idx      = tag;
    p.dest_reg_idx = tag[4:0] ^ 5'h15;
    return p;
  endfunction

  task automatic set_rr(input int i, input DATA a, input DATA b);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    p.rs1_value = a; p.rs2_value = b;
    p.opa_select = OPA_IS_RS1; p.opb_select = OPB_IS_RS2;
    req_pack[i] = p; exp_sum[i] = a + b;
  endtask

  task automatic set_npc(input int i, input DATA npc, input DATA b);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    p.NPC = npc; p.rs2_value = b;
    p.opa_select = OPA_IS_NPC; p.opb_select = OPB_IS_RS2;
    req_pack[i] = p; exp_sum[i] = npc + b;
  endtask

  task automatic set_pcj(input int i, input DATA pc, input int imm);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    logic [20:0] j = imm[20:0];
    p.PC = pc; p.inst = {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'h6f};
    p.opa_select = OPA_IS_PC; p.opb_select = OPB_IS_J_IMM;
    req_pack[i] = p; exp_sum[i] = pc + DATA'(imm);
  endtask

  task automatic set_pcb(input int i, input DATA pc, input int imm);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    logic [12:0] b = imm[12:0];
    p.PC = pc; p.inst = {b[12], b[10:5], 5'd3, 5'd4, 3'b000, b[4:1], b[11], 7'h63};
    p.opa_select = OPA_IS_PC; p.opb_select = OPB_IS_B_IMM;
    req_pack[i] = p; exp_sum[i] = pc + DATA'(imm);
  endtask

  task automatic set_ri(input int i, input DATA a, input int imm);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    logic [11:0] s = imm[11:0];
    p.rs1_value = a; p.inst = {s, 5'd2, 3'b000, 5'd5, 7'h13};
    p.opa_select = OPA_IS_RS1; p.opb_select = OPB_IS_I_IMM;
    req_pack[i] = p; exp_sum[i] = a + DATA'(imm);
  endtask

  task automatic set_rs(input int i, input DATA a, input int imm);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    logic [11:0] s = imm[11:0];
    p.rs1_value = a; p.inst = {s[11:5], 5'd6, 5'd7, 3'b010, s[4:0], 7'h23};
    p.opa_select = OPA_IS_RS1; p.opb_select = OPB_IS_S_IMM;
    req_pack[i] = p; exp_sum[i] = a + DATA'(imm);
  endtask

  task automatic set_zu(input int i, input DATA u);
    ISSUE_PACKET p = base_pack(rob_ctr++);
    p.inst = {u[31:12], 5'd8, 7'h37};
    p.opa_select = OPA_IS_ZERO; p.opb_select = OPB_IS_U_IMM;
    req_pack[i] = p; exp_sum[i] = {u[31:12], 12'b0};
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] acc;
    exp_t e;
    #1;
    acc = req_valid & req_ready;
    chk("grant_onehot0", $onehot0(req_ready), 1'b1);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_result", out_result, e.result);
        chk("sb_src", out_src, e.src);
        chk("sb_pack", out_pack, e.pack);
      end
    end
    if (flush) sb_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        sb_q.push_back('{src: IDX_W'(i), result: exp_sum[i], pack: req_pack[i]});
        n_acc++;
      end
    end
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) set_rr(i, $urandom, $urandom);
  endtask

  task automatic drain(input string tag);
    req_valid = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk(tag, sb_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) set_rr(i, $urandom, $urandom);

    // Reset state, with every requester asking
    @(negedge clock);
    reset = 1'b1; req_valid = '1;
    @(negedge clock); @(negedge clock);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_pack", out_pack, 0);
    reset = 1'b0; req_valid = '0;
    @(negedge clock);

    // Fairness: all valid -> 0,1,2,0,1,2
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = '0;
      exp_gnt[k % NUM_REQ] = 1'b1;
      #1 chk("rr_grant", req_ready, exp_gnt);
      cycle();
    end
    drain("fair_drain");

    // Single request, 2-cycle latency, valid for exactly one cycle
    set_rr(0, 32'd5, 32'd7);
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    chk("single_lat1_valid", out_valid, 0);
    cycle();
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 32'd12);
    chk("single_src", out_src, 0);
    cycle();
    chk("single_gone", out_valid, 0);

    // Backpressure on a stream from req 1
    n_acc = 0; out_ready = 1'b0; req_valid = 3'b010;
    cycle(); cycle();
    chk("bp_s2_valid", out_valid, 1);
    held_res = out_result;
    repeat (2) begin
      chk("bp_ready_low", req_ready, 0);
      cycle();
      chk("bp_hold", out_result, held_res);
    end
    chk("bp_accepted", n_acc, 2);
    out_ready = 1'b1;
    #1 chk("bp_release_grant", req_ready, 3'b010);
    cycle();
    chk("bp_release_valid", out_valid, 1);
    drain("bp_drain");

    // Immediate and PC operand forms
    set_pcj(0, 32'h100, -8);
    req_valid = 3'b001; cycle();
    set_zu(2, 32'h12345000);
    req_valid = 3'b100; cycle();
    chk("j_imm", out_result, 32'h0000_00F8);
    set_ri(1, 32'd1000, -1);
    req_valid = 3'b010; cycle();
    chk("u_imm", out_result, 32'h1234_5000);
    set_pcb(0, 32'h2000, -16);
    req_valid = 3'b001; cycle();
    set_rs(2, 32'h40, 2047);
    req_valid = 3'b100; cycle();
    set_npc(1, 32'h304, 32'h10);
    req_valid = 3'b010; cycle();
    drain("imm_drain");

    // Flush with both stages full, req 2 requesting, pointer at 2
    out_ready = 1'b0; req_valid = 3'b010;
    cycle(); cycle();
    req_valid = 3'b100; flush = 1'b1; out_ready = 1'b1;
    #1 chk("flush_no_grant", req_ready, 0);
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    req_valid = '1;
    #1 chk("flush_next_grant", req_ready, 3'b100);
    cycle();
    drain("flush_drain");

    // Asynchronous reset between edges with both stages full
    out_ready = 1'b0; req_valid = 3'b001;
    cycle(); cycle();
    chk("ar_full", out_valid, 1);
    req_valid = '1;
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_result", out_result, 0);
    chk("ar_req_ready", req_ready, 0);
    sb_q.delete();
    req_valid = '0;
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    out_ready = 1'b1; req_valid = 3'b010;
    #1 chk("ar_first_grant", req_ready, 3'b010);
    cycle();
    req_valid = '0;
    chk("ar_lat1", out_valid, 0);
    cycle();
    chk("ar_lat2_valid", out_valid, 1);
    chk("ar_lat2_src", out_src, 1);
    drain("ar_drain");

    // Random traffic with random backpressure and occasional flush
    for (int n = 0; n < 300; n++) begin
      req_valid = NUM_REQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_issue_arbiter.md
# adder_issue_arbiter

Shares one `basic_adder` among several issue-side requesters (load/store address generation, JAL/JALR/AUIPC target computation) in the R10K pipeline. Each cycle it grants at most one valid requester in round-robin order, registers the winning `ISSUE_PACKET` into an operand stage that drives the adder, and registers the sum into a result stage with a valid/ready handshake toward the consumer. A synchronous `flush` squashes all in-flight work on branch recovery.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal range 2..8.
- `IDX_W`, default `$clog2(NUM_REQ)`: requester index width; derived, never overridden.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flush`  in  1  synchronous squash of both stages (branch mispredict recovery).
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_pack`  in  ISSUE_PACKET [NUM_REQ]  per-requester operand/decode packet.
- `req_ready`  out  NUM_REQ  grant; one-hot or zero; request i is accepted at the edge where `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1  result stage holds a valid sum.
- `out_result`  out  DATA  registered adder sum.
- `out_src`  out  IDX_W  index of the requester that produced `out_result`.
- `out_pack`  out  ISSUE_PACKET  packet that produced `out_result` (carries dest tag/ROB index).
- `out_ready`  in  1  consumer accepts the result at the edge where `out_valid & out_ready`.

## Operation
- Two stages: S1 (operand register: `s1_valid`, `s1_pack`, `s1_src`) and S2 (result register: `out_valid`, `out_result`, `out_pack`, `out_src`).
- The adder instance takes `s1_pack`; its combinational sum is captured into S2.
- Advance rules: `s2_free = !out_valid | out_ready`; `s1_adv = s1_valid & s2_free`; `s1_free = !s1_valid | s2_free`.
- Grant: when `s1_free & !flush`, the first valid requester at or after `rr_ptr` (wrapping modulo NUM_REQ) gets `req_ready`; otherwise `req_ready` is all zero.
- `req_ready` depends combinationally on `req_valid`; requesters do not make `req_valid` depend on `req_ready`.
- Round-robin pointer: after a grant to index g, `rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1`; unchanged when nothing is granted.
- S1 update: on grant, load the packet and index and set `s1_valid=1`; else if `s1_adv`, set `s1_valid=0`; else hold.
- S2 update: if `s1_adv`, load sum, packet and `s1_src`, and set `out_valid=1`; else if `out_ready`, set `out_valid=0`; else hold all fields stable.
- Flush: at the flush edge, `s1_valid` and `out_valid` both become 0, no grant occurs, and any in-progress consumer handshake in that cycle still completes. `rr_ptr` is unchanged.
- Data fields of invalid stages are don't-care, except immediately after reset.

## Timing
- Reset (asynchronous): `s1_valid=0`, `out_valid=0`, `out_result=0`, `out_src=0`, `out_pack='0`, `rr_ptr=0`. `req_ready` is all zero during reset.
- Latency: request accepted at edge k gives `out_valid=1` with its result in the cycle after edge k+1 (2 cycles), when there is no backpressure.
- Throughput: one result per cycle while `out_ready=1`.
- Backpressure: with `out_ready=0`, S2 holds, S1 fills, and then `req_ready` drops to 0. There are no bubbles on release: the cycle `out_ready` rises, S1 moves to S2 and a new grant loads S1.
- Simultaneous drain and fill: with S2 full, `out_ready=1` and S1 valid, the same edge pops S2, moves S1 to S2 and accepts a new request.
- Reset asserted mid-operation discards all in-flight work. The first grant after reset goes to the lowest valid index.

## Test plan
- Single request: req 0 with OPA_IS_RS1 rs1=5 and OPB_IS_RS2 rs2=7, `out_ready=1` -> two cycles later `out_valid=1`, `out_result=12`, `out_src=0`, held for one cycle.
- Fairness: all three requesters valid continuously, NUM_REQ=3 -> grant order 0,1,2,0,1,2; `out_src` follows the same order and `req_ready` is never more than one-hot.
- Backpressure: stream from req 1 with `out_ready=0` for 4 cycles -> S2 and `out_result` stay stable, exactly 2 packets are accepted, and `req_ready=0` until `out_ready=1`. No result is lost or duplicated.
- Immediate and PC operands: OPA_IS_PC PC=0x100 with OPB_IS_J_IMM imm=-8 -> `out_result=0x0F8`. OPA_IS_ZERO with OPB_IS_U_IMM 0x12345000 -> 0x12345000.
- Flush: flush asserted while S1 and S2 are both valid and req 2 is requesting -> `out_valid=0` next cycle, no grant that cycle, `rr_ptr` unchanged, and the next grant goes to req 2.
- Asynchronous reset pulsed between clock edges with both stages full -> `out_valid` and `out_result` go to 0 immediately, and after release req 1 alone is granted with 2-cycle latency.
